exec_control_core: RTL and testbench
====================================

EXEC_CONTROL_CORE -- requirements
Module: exec_control_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port program_mode, input, 1 bit: high means instruction memory is being loaded externally.
REQ-004 SHALL have port opcode, input, 4 bits: current instruction opcode.
REQ-005 SHALL have ports a_in and b_in, input, 24 bits each: ALU operands A and B (register file outputs).
REQ-006 SHALL have port imm, input, 13 bits: {reg_source_2, immediate} instruction field.
REQ-007 SHALL have port alu_out, output, 24 bits: registered ALU result.
REQ-008 SHALL have port dmem_read_data, output, 24 bits: registered data-memory read word.
REQ-009 SHALL have 1-bit control outputs ir_enable, imem_read, imem_write, dmem_read, dmem_write, alu_reg_enable, alu_src_B, alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable, pc_enable and pc_increment, plus 2-bit select_reg_write_data (0 = dmem, 1 = imm, 2 = alu_out).

Function
REQ-010 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SLL, 8 SRL, 9 ADDI, A SLT, B LOAD, C STORE, D LOADI, E BRANCH, F JUMP.
REQ-011 The ALU SHALL be combinational on A = a_in and B = (alu_src_B ? zero-extended imm : b_in).
REQ-012 All ALU results SHALL be 24 bits; ADD, SUB and ADDI SHALL wrap modulo 2^24.
REQ-013 SLL and SRL SHALL shift by B[4:0]; a shift amount of 24 or more SHALL give 0.
REQ-014 SLT SHALL give 1 when A < B (signed two's complement), else 0.
REQ-015 Opcodes 0 and B-F SHALL give an ALU result of 0.
REQ-016 alu_out SHALL load the ALU result on the clock edge where alu_out_reg_enable = 1, and SHALL otherwise hold.
REQ-017 FSM states SHALL be PROGRAM, FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
REQ-018 Control outputs SHALL be decoded combinationally from state, opcode and alu_out[0]; any output not listed for a state SHALL be 0.
REQ-019 PROGRAM: imem_write = 1; SHALL go to FETCH on the first edge with program_mode = 0.
REQ-020 From any state, program_mode = 1 SHALL force PROGRAM at the next edge and abort the current instruction.
REQ-021 FETCH: imem_read = 1 and ir_enable = 1; next state DECODE.
REQ-022 DECODE: alu_reg_enable = 1; next state EXECUTE.
REQ-023 EXECUTE for ALU opcodes 1-A: alu_out_reg_enable = 1, alu_src_B = (opcode == 9); next state WRITEBACK.
REQ-024 EXECUTE for LOAD: dmem_read = 1; next state MEM. MEM: dmem_out_reg_enable = 1; next state WRITEBACK with select_reg_write_data = 0.
REQ-025 WRITEBACK: reg_write_enable = 1, select = 2 for ALU opcodes or 0 for LOAD, pc_enable = 1, pc_increment = 1; next state FETCH.
REQ-026 EXECUTE for STORE: dmem_write = 1, pc_enable = 1, pc_increment = 1; next state FETCH.
REQ-027 EXECUTE for LOADI: reg_write_enable = 1, select = 1, pc_enable = 1, pc_increment = 1; next state FETCH.
REQ-028 EXECUTE for NOP: pc_enable = 1, pc_increment = 1; next state FETCH.
REQ-029 EXECUTE for BRANCH: pc_enable = 1, pc_increment = ~alu_out[0] (taken when alu_out[0] = 1); next state FETCH.
REQ-030 EXECUTE for JUMP: pc_enable = 1, pc_increment = 0; next state FETCH.
REQ-031 pc_enable SHALL be asserted exactly once per completed instruction.
REQ-032 Instruction latencies SHALL be: ALU 4 cycles, LOAD 5, STORE/LOADI/NOP/BRANCH/JUMP 3.
REQ-033 Data memory SHALL be 16384 x 24 bits with address {1'b0, imm}.
REQ-034 A write SHALL store a_in on the edge where dmem_write = 1.
REQ-035 dmem_read_data SHALL load mem[addr] on the edge where dmem_read = 1 (old data if written on the same edge), and SHALL otherwise hold.

Reset
REQ-036 While reset = 1, all control outputs SHALL be 0.
REQ-037 At a reset edge, the state SHALL go to PROGRAM if program_mode = 1, else FETCH; alu_out and dmem_read_data SHALL become 0.
REQ-038 Memory contents SHALL NOT be cleared by reset.
REQ-039 Reset SHALL take priority over program_mode and over any state mid-instruction.

Structure
REQ-040 A shared package SHALL hold the opcode constants, the FSM state enum and the select_reg_write_data encodings.
REQ-041 The ALU SHALL be one sub-module named exec_alu; the FSM and data memory SHALL be in the top module.

Verification
REQ-042 ADD: a_in = 0xFFFFFF, b_in = 2 -> alu_out = 0x000001 after EXECUTE; reg_write_enable = 1 and select = 2 in WRITEBACK; 4 cycles total.
REQ-043 SLT then BRANCH: a_in = 0xFFFFFE (-2), b_in = 1 -> alu_out = 1; the following BRANCH shows pc_enable = 1, pc_increment = 0.
REQ-044 STORE then LOAD: a_in = 0x123456, imm = 0x0042 -> after LOAD's MEM state dmem_read_data = 0x123456, with dmem_out_reg_enable = 1 in MEM.
REQ-045 SLL: a_in = 1, b_in = 23 -> 0x800000; b_in = 24 -> 0; ADDI with imm = 0x1FFF, a_in = 1 -> 0x002000.
REQ-046 program_mode raised mid-EXECUTE -> PROGRAM next edge, imem_write = 1, no pc_enable; release -> FETCH with imem_read = 1.
REQ-047 reset during a LOAD's MEM state -> all outputs 0, alu_out = 0, dmem_read_data = 0, and the next state is FETCH.

Source files
------------

// File: rtl/exec_control_core_pkg.sv
// exec_control_core_pkg: shared opcodes, FSM states and write-back select encodings
package exec_control_core_pkg;
  typedef enum logic [2:0] {
    ST_PROGRAM,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK
  } state_t;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_OR     = 4'h4;
  localparam logic [3:0] OP_XOR    = 4'h5;
  localparam logic [3:0] OP_NOT    = 4'h6;
  localparam logic [3:0] OP_SLL    = 4'h7;
  localparam logic [3:0] OP_SRL    = 4'h8;
  localparam logic [3:0] OP_ADDI   = 4'h9;
  localparam logic [3:0] OP_SLT    = 4'hA;
  localparam logic [3:0] OP_LOAD   = 4'hB;
  localparam logic [3:0] OP_STORE  = 4'hC;
  localparam logic [3:0] OP_LOADI  = 4'hD;
  localparam logic [3:0] OP_BRANCH = 4'hE;
  localparam logic [3:0] OP_JUMP   = 4'hF;
  localparam logic [1:0] SEL_DMEM = 2'd0;
  localparam logic [1:0] SEL_IMM  = 2'd1;
  localparam logic [1:0] SEL_ALU  = 2'd2;
  localparam int DMEM_DEPTH = 16384;
  function automatic logic is_alu_op(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_SLT;
  endfunction
endpackage

// File: rtl/exec_control_core_alu.sv
// exec_alu: combinational 24-bit ALU for the register-register and immediate opcodes
module exec_alu
  import exec_control_core_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic [23:0] o_result
);
  logic w_big_shift;
  assign w_big_shift = i_b[4:0] >= 5'd24;
  // result per opcode; non-ALU opcodes produce zero
  always_comb begin
    o_result = '0;
    case (i_opcode)
      OP_ADD, OP_ADDI: o_result = i_a + i_b;
      OP_SUB:          o_result = i_a - i_b;
      OP_AND:          o_result = i_a & i_b;
      OP_OR:           o_result = i_a | i_b;
      OP_XOR:          o_result = i_a ^ i_b;
      OP_NOT:          o_result = ~i_a;
      OP_SLL:          o_result = w_big_shift ? '0 : i_a << i_b[4:0];
      OP_SRL:          o_result = w_big_shift ? '0 : i_a >> i_b[4:0];
      OP_SLT:          o_result = {23'd0, $signed(i_a) < $signed(i_b)};
      default:         o_result = '0;
    endcase
  end
endmodule

// File: rtl/exec_control_core.sv
// exec_control_core: multi-cycle control FSM with ALU result register and data memory
module exec_control_core
  import exec_control_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        program_mode,
  input  logic [3:0]  opcode,
  input  logic [23:0] a_in,
  input  logic [23:0] b_in,
  input  logic [12:0] imm,
  output logic [23:0] alu_out,
  output logic [23:0] dmem_read_data,
  output logic        ir_enable,
  output logic        imem_read,
  output logic        imem_write,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        alu_reg_enable,
  output logic        alu_src_B,
  output logic        alu_out_reg_enable,
  output logic        dmem_out_reg_enable,
  output logic        reg_write_enable,
  output logic        pc_enable,
  output logic        pc_increment,
  output logic [1:0]  select_reg_write_data
);
  state_t      r_state, w_next;
  logic [23:0] r_alu_out, r_dmem_read_data, w_alu_b, w_alu_result;
  logic [13:0] w_addr;
  logic [23:0] r_mem [DMEM_DEPTH];
  assign w_alu_b = alu_src_B ? {11'd0, imm} : b_in;
  assign w_addr = {1'b0, imm};
  assign alu_out = r_alu_out;
  assign dmem_read_data = r_dmem_read_data;
  exec_alu u_alu (
    .i_opcode(opcode),
    .i_a     (a_in),
    .i_b     (w_alu_b),
    .o_result(w_alu_result)
  );
  // state register; reset picks the entry state from program_mode
  always_ff @(posedge clk) begin
    if (reset) r_state <= program_mode ? ST_PROGRAM : ST_FETCH;
    else r_state <= w_next;
  end
  // next state; program_mode aborts whatever instruction is in flight
  always_comb begin
    w_next = r_state;
    if (program_mode) w_next = ST_PROGRAM;
    else begin
      case (r_state)
        ST_PROGRAM:   w_next = ST_FETCH;
        ST_FETCH:     w_next = ST_DECODE;
        ST_DECODE:    w_next = ST_EXECUTE;
        ST_EXECUTE:   w_next = is_alu_op(opcode) ? ST_WRITEBACK : opcode == OP_LOAD ? ST_MEM : ST_FETCH;
        ST_MEM:       w_next = ST_WRITEBACK;
        ST_WRITEBACK: w_next = ST_FETCH;
        default:      w_next = ST_FETCH;
      endcase
    end
  end
  // control decode from state, opcode and the branch flag; silent while in reset
  always_comb begin
    ir_enable = 1'b0;
    imem_read = 1'b0;
    imem_write = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    alu_reg_enable = 1'b0;
    alu_src_B = 1'b0;
    alu_out_reg_enable = 1'b0;
    dmem_out_reg_enable = 1'b0;
    reg_write_enable = 1'b0;
    pc_enable = 1'b0;
    pc_increment = 1'b0;
    select_reg_write_data = SEL_DMEM;
    if (!reset) begin
      case (r_state)
        ST_PROGRAM: imem_write = 1'b1;
        ST_FETCH: begin
          imem_read = 1'b1;
          ir_enable = 1'b1;
        end
        ST_DECODE: alu_reg_enable = 1'b1;
        ST_EXECUTE: begin
          if (is_alu_op(opcode)) begin
            alu_out_reg_enable = 1'b1;
            alu_src_B = opcode == OP_ADDI;
          end else if (opcode == OP_LOAD) dmem_read = 1'b1;
          else begin
            pc_enable = 1'b1;
            pc_increment = opcode == OP_JUMP ? 1'b0 : opcode == OP_BRANCH ? ~r_alu_out[0] : 1'b1;
            dmem_write = opcode == OP_STORE;
            reg_write_enable = opcode == OP_LOADI;
            select_reg_write_data = opcode == OP_LOADI ? SEL_IMM : SEL_DMEM;
          end
        end
        ST_MEM: dmem_out_reg_enable = 1'b1;
        ST_WRITEBACK: begin
          reg_write_enable = 1'b1;
          select_reg_write_data = is_alu_op(opcode) ? SEL_ALU : SEL_DMEM;
          pc_enable = 1'b1;
          pc_increment = 1'b1;
        end
        default: ;
      endcase
    end
  end
  // ALU result register
  always_ff @(posedge clk) begin
    if (reset) r_alu_out <= '0;
    else if (alu_out_reg_enable) r_alu_out <= w_alu_result;
  end
  // read register samples the pre-write word when read and write share an edge
  always_ff @(posedge clk) begin
    if (reset) r_dmem_read_data <= '0;
    else if (dmem_read) r_dmem_read_data <= r_mem[w_addr];
  end
  // data memory array, deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (dmem_write) r_mem[w_addr] <= a_in;
  end
endmodule

// File: tb/tb_exec_control_core.sv
// tb_exec_control_core: directed stimulus checked every cycle against an instruction-step model
module tb_exec_control_core;
  logic        clk = 1'b0;
  logic        reset, program_mode;
  logic [3:0]  opcode;
  logic [23:0] a_in, b_in;
  logic [12:0] imm;
  logic [23:0] alu_out, dmem_read_data;
  logic        ir_enable, imem_read, imem_write, dmem_read, dmem_write, alu_reg_enable, alu_src_B;
  logic        alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable, pc_enable, pc_increment;
  logic [1:0]  select_reg_write_data;
  logic [13:0] ctrl;
  int nchk = 0, nfail = 0;

  exec_control_core dut (
    .clk(clk), .reset(reset), .program_mode(program_mode), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .imm(imm), .alu_out(alu_out), .dmem_read_data(dmem_read_data),
    .ir_enable(ir_enable), .imem_read(imem_read), .imem_write(imem_write),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .alu_reg_enable(alu_reg_enable),
    .alu_src_B(alu_src_B), .alu_out_reg_enable(alu_out_reg_enable),
    .dmem_out_reg_enable(dmem_out_reg_enable), .reg_write_enable(reg_write_enable),
    .pc_enable(pc_enable), .pc_increment(pc_increment),
    .select_reg_write_data(select_reg_write_data)
  );

  always #5 clk = ~clk;

  assign ctrl = {ir_enable, imem_read, imem_write, dmem_read, dmem_write, alu_reg_enable, alu_src_B,
                 alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable, pc_enable, pc_increment,
                 select_reg_write_data};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit is_alu(input logic [3:0] op);
    return op inside {[4'd1:4'd10]};
  endfunction

  function automatic int lat(input logic [3:0] op);
    return is_alu(op) ? 4 : op == 4'hB ? 5 : 3;
  endfunction

  // expected controls for a given step of the instruction (0 = first cycle after the previous one)
  function automatic logic [13:0] exp_ctrl(input bit rst, input bit prog, input int step,
                                           input logic [3:0] op, input bit a0);
    bit ir = 0, ird = 0, iwr = 0, drd = 0, dwr = 0, are = 0, asb = 0, aoe = 0, doe = 0;
    bit rwe = 0, pce = 0, pci = 0;
    logic [1:0] sel = 2'd0;
    if (!rst) begin
      if (prog) iwr = 1;
      else if (step == 0) begin ir = 1; ird = 1; end
      else if (step == 1) are = 1;
      else if (step == 2) begin
        if (is_alu(op)) begin aoe = 1; asb = (op == 4'h9); end
        else if (op == 4'hB) drd = 1;
        else begin
          pce = 1;
          pci = (op == 4'hF) ? 0 : (op == 4'hE) ? !a0 : 1;
          dwr = (op == 4'hC);
          if (op == 4'hD) begin rwe = 1; sel = 2'd1; end
        end
      end else if (step == 3 && op == 4'hB) doe = 1;
      else begin rwe = 1; pce = 1; pci = 1; sel = is_alu(op) ? 2'd2 : 2'd0; end
    end
    return {ir, ird, iwr, drd, dwr, are, asb, aoe, doe, rwe, pce, pci, sel};
  endfunction

  function automatic logic [23:0] ref_alu(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
    longint m = 64'd1 << 24;
    longint x = longint'(a), y = longint'(b), r = 0;
    longint sx = (x >= m / 2) ? x - m : x;
    longint sy = (y >= m / 2) ? y - m : y;
    int sh = int'(b[4:0]);
    case (op)
      4'h1, 4'h9: r = (x + y) % m;
      4'h2: r = (x - y + m) % m;
      4'h3: r = x & y;
      4'h4: r = x | y;
      4'h5: r = x ^ y;
      4'h6: r = m - 1 - x;
      4'h7: r = (sh >= 24) ? 0 : (x << sh) % m;
      4'h8: r = (sh >= 24) ? 0 : x >> sh;
      4'hA: r = (sx < sy) ? 1 : 0;
      default: r = 0;
    endcase
    return r[23:0];
  endfunction

  bit m_valid = 0, m_prog = 0;
  int m_step = 0;
  logic [23:0] m_alu = 0, m_rd = 0;
  logic [23:0] m_mem [int];

  // model: apply the effects of this cycle's expected controls, then advance the instruction step
  always @(posedge clk) begin
    logic [13:0] c;
    int addr;
    c = exp_ctrl(reset, m_prog, m_step, opcode, m_alu[0]);
    addr = int'(imm);
    m_valid = 1;
    if (reset) begin
      m_prog = program_mode; m_step = 0; m_alu = 0; m_rd = 0;
    end else begin
      if (c[6]) m_alu = ref_alu(opcode, a_in, c[7] ? {11'd0, imm} : b_in);
      if (c[10]) m_rd = m_mem.exists(addr) ? m_mem[addr] : 24'd0;
      if (c[9]) m_mem[addr] = a_in;
      if (program_mode) begin m_prog = 1; m_step = 0; end
      else if (m_prog) begin m_prog = 0; m_step = 0; end
      else m_step = (m_step + 1 == lat(opcode)) ? 0 : m_step + 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ctrl", 32'(ctrl), 32'(exp_ctrl(reset, m_prog, m_step, opcode, m_alu[0])));
      chk("alu_out", 32'(alu_out), 32'(m_alu));
      chk("dmem_read_data", 32'(dmem_read_data), 32'(m_rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b, input logic [12:0] im);
    opcode = op; a_in = a; b_in = b; imm = im;
  endtask

  task automatic run(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b, input logic [12:0] im);
    set(op, a, b, im);
    repeat (lat(op)) cyc();
  endtask

  task automatic run_chk(input string n, input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [12:0] im, input logic [23:0] exp);
    run(op, a, b, im);
    @(negedge clk);
    chk(n, 32'(alu_out), 32'(exp));
  endtask

  initial begin
    reset = 1; program_mode = 1;
    set(4'h0, 0, 0, 0);
    cyc(); cyc();
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 0);
    chk("reset_alu", 32'(alu_out), 0);
    chk("reset_rd", 32'(dmem_read_data), 0);
    reset = 0;
    @(negedge clk);
    chk("program_imem_write", 32'(imem_write), 1);
    cyc();
    program_mode = 0;
    cyc();
    // ADD wrap: 0xFFFFFF + 2
    set(4'h1, 24'hFFFFFF, 24'd2, 0);
    @(negedge clk);
    chk("add_fetch_imem_read", 32'(imem_read), 1);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("add_alu_out", 32'(alu_out), 32'h1);
    chk("add_wb_rwe", 32'(reg_write_enable), 1);
    chk("add_wb_sel", 32'(select_reg_write_data), 2);
    cyc();
    @(negedge clk);
    chk("add_4cyc_fetch", 32'(imem_read), 1);
    // SLT -2 < 1, then taken BRANCH
    run_chk("slt_neg", 4'hA, 24'hFFFFFE, 24'd1, 0, 24'd1);
    set(4'hE, 0, 0, 0);
    cyc(); cyc();
    @(negedge clk);
    chk("branch_pc_enable", 32'(pc_enable), 1);
    chk("branch_pc_increment", 32'(pc_increment), 0);
    cyc();
    // STORE then LOAD at 0x42
    run(4'hC, 24'h123456, 0, 13'h0042);
    set(4'hB, 0, 0, 13'h0042);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("load_mem_doe", 32'(dmem_out_reg_enable), 1);
    chk("load_mem_data", 32'(dmem_read_data), 32'h123456);
    cyc(); cyc();
    // shifts, ADDI and the remaining ALU ops
    run_chk("sll_23", 4'h7, 24'd1, 24'd23, 0, 24'h800000);
    run_chk("sll_24", 4'h7, 24'd1, 24'd24, 0, 24'h000000);
    run_chk("addi", 4'h9, 24'd1, 24'd5, 13'h1FFF, 24'h002000);
    run_chk("sub_wrap", 4'h2, 24'd0, 24'd1, 0, 24'hFFFFFF);
    run_chk("and", 4'h3, 24'hF0F0F0, 24'hFF00FF, 0, 24'hF000F0);
    run_chk("or", 4'h4, 24'hF0F0F0, 24'h0F0000, 0, 24'hFFF0F0);
    run_chk("xor", 4'h5, 24'hFFFF00, 24'h0F0F0F, 0, 24'hF0F00F);
    run_chk("not", 4'h6, 24'h00FF00, 24'd0, 0, 24'hFF00FF);
    run_chk("srl_23", 4'h8, 24'h800000, 24'd23, 0, 24'h000001);
    run_chk("srl_30", 4'h8, 24'h800000, 24'd30, 0, 24'h000000);
    run_chk("slt_false", 4'hA, 24'd1, 24'hFFFFFF, 0, 24'h000000);
    run(4'hE, 0, 0, 0);
    run(4'h0, 0, 0, 0);
    run(4'hD, 0, 0, 13'h0ABC);
    run(4'hF, 0, 0, 0);
    // program_mode during EXECUTE aborts the instruction
    set(4'h1, 24'd5, 24'd7, 0);
    cyc(); cyc();
    program_mode = 1;
    cyc();
    @(negedge clk);
    chk("abort_imem_write", 32'(imem_write), 1);
    chk("abort_no_pc_enable", 32'(pc_enable), 0);
    program_mode = 0;
    cyc();
    @(negedge clk);
    chk("release_imem_read", 32'(imem_read), 1);
    run(4'h0, 0, 0, 0);
    // reset during LOAD's MEM state
    set(4'hB, 0, 0, 13'h0042);
    cyc(); cyc(); cyc();
    reset = 1;
    @(negedge clk);
    chk("reset_mid_ctrl", 32'(ctrl), 0);
    cyc();
    reset = 0;
    @(negedge clk);
    chk("reset_mid_fetch", 32'(imem_read), 1);
    chk("reset_mid_alu", 32'(alu_out), 0);
    chk("reset_mid_rd", 32'(dmem_read_data), 0);
    run(4'h0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
